adder_nnbit_seq_ctrl: RTL and testbench
=======================================

ADDER_NNBIT_SEQ_CTRL -- requirements
Module: adder_nnbit_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: chunk width of the single internal nnbit serial carry adder.
REQ-002 Parameter CHUNK_NUM, default 4, legal range 1 or more: number of chunks; total operand width W = DATA_WIDTH*CHUNK_NUM.
REQ-003 Port i_clk, input, 1 bit: the block's only clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port i_valid, input, 1 bit: request valid.
REQ-006 Port o_ready, output, 1 bit: block accepts a request.
REQ-007 Port i_num_a, input, W bits: operand a.
REQ-008 Port i_num_b, input, W bits: operand b.
REQ-009 Port i_cry, input, 1 bit: carry into bit 0.
REQ-010 Port o_valid, output, 1 bit: result valid.
REQ-011 Port i_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port o_res, output, W bits: sum, registered.
REQ-013 Port o_cry, output, 1 bit: carry out of bit W-1, registered.

Function
REQ-014 The block SHALL contain exactly one DATA_WIDTH-bit nnbit serial carry adder and reuse it for one chunk per cycle, LSB chunk first.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE; both SHALL be decoded from the state register.
REQ-017 In IDLE, i_valid=1 SHALL be accepted on that edge: a, b and the carry are captured, the chunk index is cleared to 0 and the FSM moves to CALC.
REQ-018 In CALC, each edge SHALL write adder chunk result idx into o_res[idx*DATA_WIDTH +: DATA_WIDTH], register the chunk carry-out as the next chunk carry-in and increment idx.
REQ-019 On the CALC edge with idx = CHUNK_NUM-1, the final carry SHALL load o_cry and the FSM SHALL move to DONE.
REQ-020 o_valid SHALL rise exactly CHUNK_NUM edges after the accepting edge; throughput SHALL be one operation per CHUNK_NUM+2 cycles at minimum.
REQ-021 In DONE, o_res and o_cry SHALL stay stable until i_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-022 i_valid in CALC or DONE SHALL be ignored; i_ready outside DONE SHALL be ignored.
REQ-023 Input changes after acceptance SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be modulo 2^W, with the overflow reported only on o_cry.
REQ-025 When CHUNK_NUM=1, CALC SHALL last exactly one cycle.

Reset
REQ-026 While i_rst_n=0, regardless of the clock, the state SHALL be IDLE, the chunk index 0 and the internal carry 0.
REQ-027 While i_rst_n=0, o_res SHALL be 0, o_cry 0, o_valid 0 and o_ready 1.
REQ-028 Reset in CALC or DONE SHALL abort the operation; no o_valid pulse SHALL follow.

Configuration
REQ-029 When the macro ADDER_SEQ_SUB_EN is defined, an input port i_sub (1 bit) SHALL exist.
REQ-030 With ADDER_SEQ_SUB_EN defined and i_sub=1 at acceptance, ~i_num_b SHALL be captured and the carry-in forced to 1, with i_cry ignored; the result is a-b, and o_cry=1 means no borrow.
REQ-031 When ADDER_SEQ_SUB_EN is undefined, i_sub SHALL be absent and the block SHALL only add.

Verification (DATA_WIDTH=8, CHUNK_NUM=4)
REQ-032 a=0x000000FF, b=0x00000001, i_cry=0 -> o_res=0x00000100, o_cry=0, with o_valid rising 4 edges after acceptance.
REQ-033 a=0xFFFFFFFF, b=0x00000000, i_cry=1 -> o_res=0x00000000, o_cry=1.
REQ-034 i_ready held 0 for 3 cycles in DONE, with i_valid=1 and new operands driven -> o_valid, o_res and o_cry unchanged and o_ready=0; a later i_ready=1 gives IDLE on the next cycle.
REQ-035 i_rst_n pulsed low during the 2nd CALC cycle -> o_res=0, o_valid=0 and o_ready=1 immediately; no result after release.
REQ-036 ADDER_SEQ_SUB_EN defined: a=5, b=7, i_sub=1 -> o_res=0xFFFFFFFE, o_cry=0; a=7, b=5, i_sub=1 -> o_res=0x00000002, o_cry=1.
REQ-037 CHUNK_NUM=1, a=0x80, b=0x80 -> o_res=0x00, o_cry=1, with o_valid 1 edge after acceptance.

Source files
------------

// File: rtl/adder_nnbit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_nnbit_seq_ctrl
//
// Multi-cycle W-bit adder (W = DATA_WIDTH*CHUNK_NUM) built around a single
// DATA_WIDTH-bit ripple ("nnbit serial carry") adder. The adder is reused once
// per cycle, least-significant chunk first, and the chunk carry is registered
// between cycles. A small IDLE -> CALC -> DONE FSM provides a valid/ready
// handshake on both the request and the result side.
//
// Configuration macro:
//   ADDER_SEQ_SUB_EN : adds input i_sub. When i_sub=1 at acceptance, the block
//                      computes a-b (b inverted, carry-in forced to 1); o_cry=1
//                      then means "no borrow". Undefined: add only.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_valid  : request valid (sampled only in IDLE)
//   o_ready  : high only in IDLE
//   i_num_a  : operand a, W bits
//   i_num_b  : operand b, W bits
//   i_cry    : carry into bit 0
//   i_sub    : subtract select (only with ADDER_SEQ_SUB_EN)
//   o_valid  : high only in DONE
//   i_ready  : result consumer ready (sampled only in DONE)
//   o_res    : registered sum, W bits
//   o_cry    : registered carry out of bit W-1
// -----------------------------------------------------------------------------
module adder_nnbit_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CHUNK_NUM  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [DATA_WIDTH*CHUNK_NUM-1:0] i_num_a,
  input  logic [DATA_WIDTH*CHUNK_NUM-1:0] i_num_b,
  input  logic                            i_cry,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                            i_sub,
`endif
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [DATA_WIDTH*CHUNK_NUM-1:0] o_res,
  output logic                            o_cry
);

  localparam int W     = DATA_WIDTH * CHUNK_NUM;
  // A one-chunk build still needs a 1-bit index register.
  localparam int IDX_W = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cry_q, cry_d;      // carry between chunks
  logic               o_cry_q, o_cry_d;

  logic [DATA_WIDTH-1:0] chunk_a;
  logic [DATA_WIDTH-1:0] chunk_b;
  logic [DATA_WIDTH-1:0] chunk_sum;
  logic                  chunk_cout;
  logic                  is_last;

  // ---------------------------------------------------------------------------
  // The single DATA_WIDTH-bit ripple-carry adder, fed by the current chunk.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic c;
    // NOTE: combinational logic uses blocking (=) so the ripple carry c is
    // visible to the next bit within the same evaluation; flops use <=.
    chunk_a   = a_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    chunk_b   = b_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    chunk_sum = '0;
    c         = cry_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ c;
      c            = (chunk_a[i] & chunk_b[i]) | (c & (chunk_a[i] ^ chunk_b[i]));
    end
    chunk_cout = c;
  end

  assign is_last = (idx_q == IDX_W'(CHUNK_NUM - 1));

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cry_d   = cry_q;
    o_cry_d = o_cry_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d   = i_num_a;
          b_d   = i_num_b;
          cry_d = i_cry;
`ifdef ADDER_SEQ_SUB_EN
          // a - b = a + ~b + 1; the external carry is not used here.
          if (i_sub) begin
            b_d   = ~i_num_b;
            cry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = chunk_sum;
        cry_d = chunk_cout;
        idx_d = idx_q + IDX_W'(1);
        if (is_last) begin
          o_cry_d = chunk_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every flop, including the operand and result registers, is reset so
  // the outputs are defined as soon as reset asserts and an aborted operation
  // leaves nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cry_q   <= 1'b0;
      o_cry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cry_q   <= cry_d;
      o_cry_q <= o_cry_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_res   = res_q;
  assign o_cry   = o_cry_q;

endmodule

// File: tb/tb_adder_nnbit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_nnbit_seq_ctrl
//
// Self-checking bench for adder_nnbit_seq_ctrl. Instance dut uses
// DATA_WIDTH=8, CHUNK_NUM=4; instance dut1 uses CHUNK_NUM=1. Expected results
// come from a vector table and from a reference model using plain W+1-bit
// arithmetic. Subtraction is exercised when ADDER_SEQ_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_nnbit_seq_ctrl;

  localparam int DW = 8;
  localparam int CN = 4;
  localparam int W  = DW * CN;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_num_a;
  logic [W-1:0] i_num_b;
  logic         i_cry;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_res;
  logic         o_cry;

  logic          c1_valid;
  logic          c1_ready;
  logic [DW-1:0] c1_a;
  logic [DW-1:0] c1_b;
  logic          c1_cin;
  logic          c1_ovalid;
  logic          c1_iready;
  logic [DW-1:0] c1_res;
  logic          c1_cry;

`ifdef ADDER_SEQ_SUB_EN
  logic i_sub;
  logic c1_sub;
`endif

  int errors = 0;
  int checks = 0;

  adder_nnbit_seq_ctrl #(.DATA_WIDTH(DW), .CHUNK_NUM(CN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .i_cry   (i_cry),
`ifdef ADDER_SEQ_SUB_EN
    .i_sub   (i_sub),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_cry   (o_cry)
  );

  adder_nnbit_seq_ctrl #(.DATA_WIDTH(DW), .CHUNK_NUM(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (c1_valid),
    .o_ready (c1_ready),
    .i_num_a (c1_a),
    .i_num_b (c1_b),
    .i_cry   (c1_cin),
`ifdef ADDER_SEQ_SUB_EN
    .i_sub   (c1_sub),
`endif
    .o_valid (c1_ovalid),
    .i_ready (c1_iready),
    .o_res   (c1_res),
    .o_cry   (c1_cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {carry, sum} of the full-width operation.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // One full transaction on dut. Inputs are scrambled after acceptance, and
  // i_valid / i_ready toggle randomly where they must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s, input int hold);
    logic [W:0] exp;
    int lat;
    exp = model(a, b, cin, s);
    @(negedge clk);
    check("idle_ready", o_ready, 1);
    i_valid = 1'b1;
    i_num_a = a;
    i_num_b = b;
    i_cry   = cin;
`ifdef ADDER_SEQ_SUB_EN
    i_sub   = s;
`endif
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!o_valid && lat < CN + 4) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_num_a = $urandom;
      i_num_b = $urandom;
      i_cry   = 1'($urandom_range(0, 1));
`ifdef ADDER_SEQ_SUB_EN
      i_sub   = 1'($urandom_range(0, 1));
`endif
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    i_ready = 1'b0;
    check("latency", lat, CN);
    check("res", o_res, exp[W-1:0]);
    check("cry", o_cry, exp[W]);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      i_num_a = $urandom;
      i_num_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid_ready", {o_valid, o_ready}, 2'b10);
      check("hold_res", o_res, exp[W-1:0]);
      check("hold_cry", o_cry, exp[W]);
    end
    i_ready = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check("back_idle", {o_ready, o_valid}, 2'b10);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;
    logic [W-1:0] res;
    logic         cry;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W:0] m;
    logic       bad;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 0, 32'h00000000, 1'b0};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 3, 32'hACF13568, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b1, 1, 32'h01000101, 1'b0};
    vecs[6] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 0, 32'h01000000, 1'b0};

    rst_n = 1'b0;
    i_valid = 1'b0; i_ready = 1'b0; i_num_a = '0; i_num_b = '0; i_cry = 1'b0;
    c1_valid = 1'b0; c1_iready = 1'b0; c1_a = '0; c1_b = '0; c1_cin = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
    i_sub = 1'b0;
    c1_sub = 1'b0;
`endif

    // Reset state before any clock edge.
    #3;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_res", o_res, 0);
    check("rst_cry", o_cry, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: expected values written by hand, also cross-checked
    // against the model.
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      check("table_model", m, {vecs[i].cry, vecs[i].res});
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].hold);
    end

`ifdef ADDER_SEQ_SUB_EN
    m = model(32'd5, 32'd7, 1'b0, 1'b1);
    check("sub_5_7_model", m, {1'b0, 32'hFFFFFFFE});
    run_op(32'd5, 32'd7, 1'b1, 1'b1, 0);
    m = model(32'd7, 32'd5, 1'b0, 1'b1);
    check("sub_7_5_model", m, {1'b1, 32'h00000002});
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 0);
`endif

    // Randomized operations against the model.
    for (int r = 0; r < 20; r++) begin
      logic s;
`ifdef ADDER_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), s, $urandom_range(0, 2));
    end

    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    i_valid = 1'b1;
    i_num_a = 32'h11111111;
    i_num_b = 32'h22222222;
    i_cry   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_res", o_res, 0);
    check("abort_valid", o_valid, 0);
    check("abort_ready", o_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (CN + 3) begin
      @(negedge clk);
      if (o_valid) bad = 1'b1;
    end
    check("abort_no_valid", bad, 0);
    check("abort_idle", o_ready, 1);

    // CHUNK_NUM=1: one CALC cycle.
    @(negedge clk);
    check("c1_ready", c1_ready, 1);
    c1_valid = 1'b1;
    c1_a = 8'h80;
    c1_b = 8'h80;
    c1_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    c1_valid = 1'b0;
    c1_a = 8'h3C;
    check("c1_calc_valid", c1_ovalid, 0);
    @(posedge clk);
    @(negedge clk);
    check("c1_done_valid", c1_ovalid, 1);
    check("c1_res", c1_res, 8'h00);
    check("c1_cry", c1_cry, 1);
    c1_iready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c1_iready = 1'b0;
    check("c1_back_idle", {c1_ready, c1_ovalid}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
